// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and instruction field positions for alu_seq
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    GTE  = 3'd2,
    LT   = 3'd3,
    NOT1 = 3'd4
  } operation_t;

  typedef struct packed {
    logic carry;
    logic zero;
  } flags_t;

  typedef enum logic [2:0] {
    OPC_ADD  = 3'd0,
    OPC_SUB  = 3'd1,
    OPC_GTE  = 3'd2,
    OPC_LT   = 3'd3,
    OPC_NOT1 = 3'd4,
    OPC_LDI  = 3'd5,
    OPC_IL6  = 3'd6,
    OPC_IL7  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RET  = 2'd2
  } state_t;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  function automatic operation_t opc_to_op(input opcode_t opc);
    case (opc)
      OPC_SUB:  return SUB;
      OPC_GTE:  return GTE;
      OPC_LT:   return LT;
      OPC_NOT1: return NOT1;
      default:  return ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_rf.sv
// rtl/alu_seq_rf.sv - 8x16 register file, two operand read ports, one debug port
module alu_seq_rf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr1,
  input  logic [2:0]  raddr2,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] rdata1,
  output logic [15:0] rdata2,
  output logic [15:0] dbg_data
);

  logic [15:0] mem [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = mem[raddr1];
  assign rdata2   = mem[raddr2];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - issue/write-back sequencer feeding an external 16-bit ALU
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic        alu_en,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  output operation_t  alu_op,
  input  logic [15:0] alu_result,
  input  flags_t      alu_fls,
  output logic        done,
  output logic        illegal,
  output logic        carry_q,
  output logic        zero_q,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  state_t      state_q, state_d;
  logic [15:0] instr_q;
  opcode_t     opc;
  logic [15:0] rs1_data, rs2_data, wdata;
  logic        rf_we, flag_we, carry_d, zero_d;
  logic        unused_flags;

  assign opc          = opcode_t'(instr_q[OPC_MSB:OPC_LSB]);
  assign unused_flags = alu_fls.zero;

  alu_seq_rf u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (instr_q[RD_MSB:RD_LSB]),
    .wdata    (wdata),
    .raddr1   (instr_q[RS1_MSB:RS1_LSB]),
    .raddr2   (instr_q[RS2_MSB:RS2_LSB]),
    .dbg_addr (dbg_addr),
    .rdata1   (rs1_data),
    .rdata2   (rs2_data),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      if (instr_valid && instr_ready) instr_q <= instr;
      if (flag_we) begin
        carry_q <= carry_d;
        zero_q  <= zero_d;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_en      = 1'b0;
    alu_op1     = '0;
    alu_op2     = '0;
    alu_op      = ADD;
    done        = 1'b0;
    illegal     = 1'b0;
    rf_we       = 1'b0;
    wdata       = '0;
    flag_we     = 1'b0;
    carry_d     = carry_q;
    zero_d      = zero_q;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_RET;
        alu_op1 = rs1_data;
        alu_op2 = (opc == OPC_NOT1) ? 16'd0 : rs2_data;
        alu_op  = opc_to_op(opc);
        alu_en  = (opc <= OPC_NOT1);
        // Result is sampled at the EXEC->RET edge; rf and flags commit together.
        case (opc)
          OPC_ADD, OPC_SUB: begin
            rf_we = 1'b1; flag_we = 1'b1;
            wdata = alu_result; carry_d = alu_fls.carry;
          end
          OPC_GTE: begin
            rf_we = 1'b1; flag_we = 1'b1;
            wdata = {15'b0, ~alu_fls.carry}; carry_d = alu_fls.carry;
          end
          OPC_LT: begin
            rf_we = 1'b1; flag_we = 1'b1;
            wdata = {15'b0, alu_fls.carry}; carry_d = alu_fls.carry;
          end
          OPC_NOT1: begin
            rf_we = 1'b1; flag_we = 1'b1;
            wdata = alu_result; carry_d = 1'b0;
          end
          OPC_LDI: begin
            rf_we = 1'b1;
            wdata = {8'b0, instr_q[IMM_MSB:IMM_LSB]};
          end
          default: ;
        endcase
        zero_d = flag_we ? (wdata == 16'd0) : zero_q;
      end
      S_RET: begin
        done    = 1'b1;
        illegal = (opc == OPC_IL6) || (opc == OPC_IL7);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural ALU and rf model
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        alu_en;
  logic [15:0] alu_op1, alu_op2;
  operation_t  alu_op;
  logic [15:0] alu_result;
  flags_t      alu_fls;
  logic        done, illegal, carry_q, zero_q;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int passed = 0;
  int total  = 0;

  logic [15:0] rf_m [8];
  logic        carry_m, zero_m;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_en      (alu_en),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_fls     (alu_fls),
    .done        (done),
    .illegal     (illegal),
    .carry_q     (carry_q),
    .zero_q      (zero_q),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Stand-in ALU: carry is carry-out for ADD and borrow (op1 < op2) for SUB/GTE/LT.
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum    = {1'b0, alu_op1} + {1'b0, alu_op2};
    alu_result = '0;
    alu_fls    = '0;
    case (alu_op)
      ADD:           begin alu_result = alu_sum[15:0]; alu_fls.carry = alu_sum[16]; end
      SUB, GTE, LT:  begin alu_result = alu_op1 - alu_op2; alu_fls.carry = (alu_op1 < alu_op2); end
      NOT1:          begin alu_result = ~alu_op1; end
      default: ;
    endcase
    alu_fls.zero = (alu_result == 16'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] mk(input logic [2:0] opc, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {opc, rd, rs1, rs2, 4'h0};
  endfunction

  function automatic logic [15:0] mk_ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {3'd5, rd, 2'b00, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    carry_m = 1'b0;
    zero_m  = 1'b0;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk(tag, dbg_data, rf_m[i]);
    end
  endtask

  // Issue one instruction and check every cycle through retirement.
  task automatic run_instr(input logic [15:0] w);
    logic [2:0]  opc, rd, rs1, rs2;
    logic [7:0]  imm;
    logic [15:0] a, b, res;
    logic        c, wr, fl;
    int          n;
    opc = w[15:13]; rd = w[12:10]; rs1 = w[9:7]; rs2 = w[6:4]; imm = w[7:0];
    a = rf_m[rs1]; b = rf_m[rs2];
    @(negedge clk);
    instr = w; instr_valid = 1'b1; n = 0;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    chk("accept_ready", instr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'($urandom);
    chk("exec_ready", instr_ready, 0);
    chk("exec_done", done, 0);
    chk("exec_alu_en", alu_en, (opc <= 3'd4));
    if (opc <= 3'd4) begin
      chk("exec_op1", alu_op1, a);
      chk("exec_op2", alu_op2, (opc == 3'd4) ? 16'd0 : b);
    end
    c = 1'b0; res = '0; wr = 1'b1; fl = 1'b1;
    case (opc)
      3'd0: {c, res} = {1'b0, a} + {1'b0, b};
      3'd1: begin res = a - b; c = (a < b); end
      3'd2: begin c = (a < b); res = (a >= b) ? 16'd1 : 16'd0; end
      3'd3: begin c = (a < b); res = (a < b) ? 16'd1 : 16'd0; end
      3'd4: res = ~a;
      3'd5: begin res = {8'h00, imm}; fl = 1'b0; end
      default: begin wr = 1'b0; fl = 1'b0; end
    endcase
    if (wr) rf_m[rd] = res;
    if (fl) begin carry_m = c; zero_m = (res == 16'd0); end
    dbg_addr = rd;
    @(negedge clk);
    chk("ret_done", done, 1);
    chk("ret_illegal", illegal, (opc >= 3'd6));
    chk("ret_ready", instr_ready, 0);
    chk("ret_alu_en", alu_en, 0);
    chk("ret_op1", alu_op1, 0);
    chk("ret_op2", alu_op2, 0);
    chk("ret_op", alu_op, ADD);
    chk("ret_rd", dbg_data, rf_m[rd]);
    chk("ret_carry", carry_q, carry_m);
    chk("ret_zero", zero_q, zero_m);
    @(negedge clk);
    chk("idle_ready", instr_ready, 1);
    chk("idle_done", done, 0);
    chk("idle_illegal", illegal, 0);
  endtask

  task automatic peek(input string tag, input logic [2:0] r, input logic [15:0] exp);
    dbg_addr = r;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b1; instr = mk_ldi(3'd1, 8'hAA); dbg_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_op1", alu_op1, 0);
    chk("rst_op2", alu_op2, 0);
    chk("rst_op", alu_op, ADD);
    chk("rst_carry", carry_q, 0);
    chk("rst_zero", zero_q, 0);
    check_rf("rst_rf");
    instr_valid = 1'b0;
    rst_n = 1'b1;

    run_instr(mk_ldi(3'd1, 8'h34));
    run_instr(mk_ldi(3'd2, 8'h12));
    run_instr(mk(3'd0, 3'd3, 3'd1, 3'd2));
    peek("add_r3", 3'd3, 16'h0046);
    chk("add_carry", carry_q, 0);
    chk("add_zero", zero_q, 0);

    run_instr(mk_ldi(3'd1, 8'hFF));
    run_instr(mk(3'd4, 3'd1, 3'd0, 3'd0));
    peek("not1_r1", 3'd1, 16'hFFFF);
    run_instr(mk_ldi(3'd2, 8'h01));
    run_instr(mk(3'd0, 3'd4, 3'd1, 3'd2));
    peek("wrap_r4", 3'd4, 16'h0000);
    chk("wrap_carry", carry_q, 1);
    chk("wrap_zero", zero_q, 1);

    run_instr(mk_ldi(3'd1, 8'h05));
    run_instr(mk_ldi(3'd2, 8'h07));
    run_instr(mk(3'd3, 3'd5, 3'd1, 3'd2));
    peek("lt_r5", 3'd5, 16'h0001);
    chk("lt_carry", carry_q, 1);
    run_instr(mk(3'd2, 3'd6, 3'd1, 3'd2));
    peek("gte_r6", 3'd6, 16'h0000);
    chk("gte_zero", zero_q, 1);
    run_instr(mk(3'd1, 3'd7, 3'd1, 3'd2));
    peek("sub_r7", 3'd7, 16'hFFFE);

    run_instr(mk(3'd6, 3'd3, 3'd1, 3'd2));
    peek("ill_r3", 3'd3, 16'h0046);
    run_instr(mk(3'd0, 3'd1, 3'd1, 3'd1));
    run_instr(16'hFFFF);

    for (int i = 0; i < 40; i++) run_instr(16'($urandom));
    check_rf("rand_rf");

    // Valid held high with a new word every cycle: accepted only every third cycle.
    @(negedge clk);
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      logic [2:0] rd;
      logic [7:0] imm;
      rd = 3'($urandom); imm = 8'($urandom);
      instr = mk_ldi(rd, imm);
      chk("burst_ready", instr_ready, (cyc % 3) == 0);
      if ((cyc % 3) != 1) begin
        chk("burst_alu_en", alu_en, 0);
        chk("burst_op1", alu_op1, 0);
        chk("burst_op2", alu_op2, 0);
      end
      if ((cyc % 3) == 0) rf_m[rd] = {8'h00, imm};
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("burst_end_ready", instr_ready, 1);
    check_rf("burst_rf");

    run_instr(mk_ldi(3'd1, 8'h21));
    run_instr(mk_ldi(3'd2, 8'h03));
    @(negedge clk);
    instr = mk(3'd0, 3'd3, 3'd1, 3'd2); instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("abort_exec_en", alu_en, 1);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("abort_done", done, 0);
      chk("abort_ready", instr_ready, 1);
      @(negedge clk);
    end
    rst_n = 1'b1;
    peek("abort_r3", 3'd3, 16'h0000);
    chk("abort_carry", carry_q, 0);
    chk("abort_zero", zero_q, 0);
    run_instr(mk_ldi(3'd3, 8'h5A));
    peek("post_rst_r3", 3'd3, 16'h005A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
